// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard for an in-order pipeline: counts in-flight writes
// per architectural register and stalls decode on RAW hazards or saturation.
module hazard_scoreboard #(
    parameter int MAX_PEND = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        use_rs1,
    input  logic        use_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_regwrite,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        stall,
    output logic [31:0] pending,
    output logic        busy,
    output logic        wb_err,
    output logic [15:0] stall_cycles
);

    localparam int CW = $clog2(MAX_PEND + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t MAX_C = cnt_t'(MAX_PEND);
    localparam cnt_t ONE_C = cnt_t'(1);

    // x0 never gets a counter; cnt_v is a read view with entry 0 tied to zero.
    cnt_t        cnt_q [1:31];
    cnt_t        cnt_d [1:31];
    cnt_t        cnt_v [32];
    logic [31:0] pending_q, pending_d;
    logic        busy_q;
    logic        wb_err_q;
    logic [15:0] stall_cycles_q;

    cnt_t        rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
    logic        haz_rs1, haz_rs2, sat_rd;
    logic        stall_c, accept, track, wb_live, wb_bad;
    logic [31:1] inc_v, dec_v;

    always_comb begin
        cnt_v[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_v[r] = cnt_q[r];
        end
    end

    always_comb begin
        rs1_cnt = cnt_v[issue_rs1];
        rs2_cnt = cnt_v[issue_rs2];
        rd_cnt  = cnt_v[issue_rd];
        wb_cnt  = cnt_v[wb_rd];

        // A last outstanding write retiring this cycle is covered by MEM/WB forwarding.
        haz_rs1 = use_rs1 && (issue_rs1 != 5'd0) && (rs1_cnt != '0) &&
                  !(wb_valid && (wb_rd == issue_rs1) && (rs1_cnt == ONE_C));
        haz_rs2 = use_rs2 && (issue_rs2 != 5'd0) && (rs2_cnt != '0) &&
                  !(wb_valid && (wb_rd == issue_rs2) && (rs2_cnt == ONE_C));
        sat_rd  = issue_regwrite && (issue_rd != 5'd0) && (rd_cnt == MAX_C);

        stall_c = issue_valid && (haz_rs1 || haz_rs2 || sat_rd);
        accept  = issue_valid && !stall_c;
        track   = accept && issue_regwrite && (issue_rd != 5'd0);
        wb_live = wb_valid && (wb_rd != 5'd0);
        wb_bad  = wb_live && (wb_cnt == '0);
    end

    always_comb begin
        inc_v     = '0;
        dec_v     = '0;
        pending_d = '0;
        for (int r = 1; r < 32; r++) begin
            inc_v[r] = track && (issue_rd == 5'(r));
            dec_v[r] = wb_live && (wb_rd == 5'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                cnt_d[r] = cnt_q[r] + ONE_C;
            end else if (dec_v[r] && !inc_v[r]) begin
                cnt_d[r] = cnt_q[r] - ONE_C;
            end
            pending_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            pending_q      <= '0;
            busy_q         <= 1'b0;
            wb_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            pending_q <= pending_d;
            busy_q    <= |pending_d;
            wb_err_q  <= wb_err_q | wb_bad;
            if (stall_c && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign stall        = stall_c;
    assign pending      = pending_q;
    assign busy         = busy_q;
    assign wb_err       = wb_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-register in-flight counts kept as
// plain integers, checked every cycle, plus hand-computed literal expectations.
module tb_hazard_scoreboard;

    localparam int MAX_PEND = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0, wb_rd = '0;
    logic        use_rs1 = 1'b0, use_rs2 = 1'b0, issue_regwrite = 1'b0, wb_valid = 1'b0;
    logic        stall, busy, wb_err;
    logic [31:0] pending;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_err = 0;
    bit checking = 1'b0;

    int mcnt [32];
    bit m_err;
    int m_sc;
    logic [49:0] exp_q [$];

    hazard_scoreboard #(.MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stall(stall), .pending(pending), .busy(busy), .wb_err(wb_err),
        .stall_cycles(stall_cycles)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model
    function automatic bit src_haz(input logic u, input logic [4:0] rs);
        return u && (rs != 0) && (mcnt[rs] > 0) &&
               !(wb_valid && (wb_rd == rs) && (mcnt[rs] == 1));
    endfunction

    function automatic bit model_stall();
        if (!issue_valid) return 1'b0;
        return src_haz(use_rs1, issue_rs1) || src_haz(use_rs2, issue_rs2) ||
               (issue_regwrite && (issue_rd != 0) && (mcnt[issue_rd] == MAX_PEND));
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = (mcnt[r] > 0);
        return p;
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        m_err = 1'b0;
        m_sc = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) mcnt[r] = 0;
                m_err = 1'b0;
                m_sc = 0;
                exp_q.delete();
            end else begin
                bit st, trk, dec_ok;
                logic [31:0] p;
                st = model_stall();
                if (st && m_sc < 65535) m_sc++;
                trk = issue_valid && !st && issue_regwrite && (issue_rd != 0);
                dec_ok = wb_valid && (wb_rd != 0) && (mcnt[wb_rd] > 0);
                if (wb_valid && (wb_rd != 0) && (mcnt[wb_rd] == 0)) m_err = 1'b1;
                if (trk) mcnt[issue_rd]++;
                if (dec_ok) mcnt[wb_rd]--;
                p = model_pending();
                exp_q.push_back({p, |p, m_err, m_sc[15:0]});
            end
        end
    end

    // scoreboard compare
    initial begin
        logic [49:0] e;
        forever begin
            @(negedge clk);
            if (checking && rst_n) begin
                chk("stall_model", {31'd0, stall}, {31'd0, model_stall()});
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pending_model", pending, e[49:18]);
                    chk("busy_model", {31'd0, busy}, {31'd0, e[17]});
                    chk("wb_err_model", {31'd0, wb_err}, {31'd0, e[16]});
                    chk("stall_cycles_model", {16'd0, stall_cycles}, {16'd0, e[15:0]});
                end
            end
        end
    end

    // driver: inputs change just after the rising edge; returns at the falling edge
    task automatic apply(input logic iv, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic wv, input logic [4:0] wr);
        @(posedge clk);
        #1;
        issue_valid = iv; issue_rs1 = rs1; use_rs1 = u1; issue_rs2 = rs2; use_rs2 = u2;
        issue_rd = rd; issue_regwrite = rw; wb_valid = wv; wb_rd = wr;
        @(negedge clk);
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        checking = 1'b1;

        idle();
        chk("reset_pending", pending, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_wb_err", {31'd0, wb_err}, 32'd0);
        chk("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);

        // basic hazard on x5
        apply(1, 0, 0, 0, 0, 5, 1, 0, 0);
        chk("basic_issue_no_stall", {31'd0, stall}, 32'd0);
        apply(1, 5, 1, 0, 0, 6, 0, 0, 0);
        chk("basic_stall1", {31'd0, stall}, 32'd1);
        chk("basic_pending5", {31'd0, pending[5]}, 32'd1);
        apply(1, 5, 1, 0, 0, 6, 0, 0, 0);
        chk("basic_stall2", {31'd0, stall}, 32'd1);
        apply(1, 5, 1, 0, 0, 6, 0, 1, 5);
        chk("basic_wb_release", {31'd0, stall}, 32'd0);
        chk("basic_pending_still", {31'd0, pending[5]}, 32'd1);
        idle();
        chk("basic_pending_clear", {31'd0, pending[5]}, 32'd0);
        chk("basic_stall_cycles", {16'd0, stall_cycles}, 32'd2);

        // forward window, then double write on x7
        apply(1, 0, 0, 0, 0, 7, 1, 0, 0);
        apply(1, 0, 0, 7, 1, 0, 0, 1, 7);
        chk("forward_no_stall", {31'd0, stall}, 32'd0);
        apply(1, 0, 0, 0, 0, 7, 1, 0, 0);
        apply(1, 0, 0, 0, 0, 7, 1, 0, 0);
        apply(1, 0, 0, 7, 1, 0, 0, 1, 7);
        chk("double_write_stall", {31'd0, stall}, 32'd1);
        apply(1, 0, 0, 7, 1, 0, 0, 1, 7);
        chk("double_write_release", {31'd0, stall}, 32'd0);

        // saturation on x9
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 0, 9, 1, 0, 0);
            chk("sat_fill", {31'd0, stall}, 32'd0);
        end
        apply(1, 0, 0, 0, 0, 9, 1, 0, 0);
        chk("sat_stall", {31'd0, stall}, 32'd1);
        apply(1, 0, 0, 0, 0, 9, 1, 1, 9);
        chk("sat_stall_during_wb", {31'd0, stall}, 32'd1);
        apply(1, 0, 0, 0, 0, 9, 1, 0, 0);
        chk("sat_release", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 0, 1, 9);

        // simultaneous tracked issue and writeback on x3
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0);
        apply(1, 0, 0, 0, 0, 3, 1, 1, 3);
        chk("simul_no_stall", {31'd0, stall}, 32'd0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 3);
        chk("simul_pending3", {31'd0, pending[3]}, 32'd1);
        idle();
        chk("simul_drained", {31'd0, pending[3]}, 32'd0);

        // rs1 = rs2 = rd on x10
        apply(1, 10, 1, 10, 1, 10, 1, 0, 0);
        chk("self_dep_no_stall", {31'd0, stall}, 32'd0);
        apply(1, 10, 1, 10, 1, 10, 1, 0, 0);
        chk("self_dep_stall", {31'd0, stall}, 32'd1);
        apply(1, 10, 1, 10, 1, 10, 1, 1, 10);
        chk("self_dep_forward", {31'd0, stall}, 32'd0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 10);

        // x0 handling and sticky error
        apply(1, 0, 1, 0, 1, 0, 1, 1, 0);
        chk("x0_no_stall", {31'd0, stall}, 32'd0);
        chk("stall_cycles_total", {16'd0, stall_cycles}, 32'd6);
        idle();
        chk("x0_pending", pending, 32'd0);
        chk("x0_busy", {31'd0, busy}, 32'd0);
        chk("x0_wb_no_err", {31'd0, wb_err}, 32'd0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 12);
        chk("err_not_yet", {31'd0, wb_err}, 32'd0);
        idle();
        chk("err_set", {31'd0, wb_err}, 32'd1);
        chk("err_pending", pending, 32'd0);
        idle();
        chk("err_sticky", {31'd0, wb_err}, 32'd1);

        // mid-run reset
        apply(1, 0, 0, 0, 0, 4, 1, 0, 0);
        apply(1, 4, 1, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_stall", {31'd0, stall}, 32'd1);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pending", pending, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
        chk("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        apply(1, 4, 1, 0, 0, 0, 0, 1, 4);
        chk("post_rst_no_stall", {31'd0, stall}, 32'd0);
        idle();
        chk("post_rst_wb_err", {31'd0, wb_err}, 32'd1);
        chk("post_rst_pending", pending, 32'd0);

        idle();
        idle();
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
